perceptron_predictor: RTL
=========================

# perceptron_predictor

Parametrised perceptron branch-direction predictor for the fetch stage. It holds a table of signed weight vectors indexed by PC and computes a dot product against a speculative global history register (GHR). It trains weights with the saturating perceptron rule on update, and repairs the speculative GHR on mispredicts. It generalises the fixed 12-bit-history, 64-entry predictor: history length, weight width, table depth and training threshold are all parameters, and it adds table init, a confidence threshold, checkpointed GHR repair and wrong-path squash.

## Interface
- GHR_LEN, 12, global history bits; also the number of non-bias weights per entry
- W_BITS, 8, signed weight width; weights saturate symmetrically to ±(2^(W_BITS-1)-1)
- IDX_BITS, 6, table index bits; the table has 2^IDX_BITS entries indexed by pc[IDX_BITS+1:2]
- THETA, 37, training threshold on |sum|
- SUM_BITS, derived, W_BITS+$clog2(GHR_LEN+1), signed sum width

- clk  in  1  clock; single clock domain
- reset  in  1  asynchronous, active-high
- lu_valid  in  1  lookup request
- lu_pc  in  32  lookup PC
- lu_ready  out  1  lookup accepted when lu_valid & lu_ready
- pred_valid  out  1  one-cycle prediction strobe
- pred_taken  out  1  predicted direction; 1 when pred_sum ≥ 0
- pred_sum  out  SUM_BITS  signed dot product
- pred_ghr  out  GHR_LEN  GHR checkpoint used for this prediction
- up_valid  in  1  resolved-branch update
- up_ready  out  1  update accepted when up_valid & up_ready
- up_pc  in  32  branch PC
- up_taken  in  1  actual direction
- up_mispred  in  1  the prediction was wrong
- up_ghr  in  GHR_LEN  pred_ghr returned from the prediction
- up_sum  in  SUM_BITS  pred_sum returned from the prediction

## Operation
- **Entry layout:** GHR_LEN+1 weights. w0 is the bias; w(i+1) pairs with GHR[i]. GHR[0] is the newest history bit; 1 means taken.
- **Sum:** sum = w0 + Σ(GHR[i] ? w(i+1) : −w(i+1)), computed sign-extended to SUM_BITS. It cannot overflow.
- **Table:** two synchronous read ports (lookup, update) and one write port. A read and a write to the same address in the same cycle returns the old data.
- **Init FSM (INIT → RUN):**
  - On reset, the table, GHR and all outputs clear.
  - INIT writes zero to entries 0..2^IDX_BITS−1, one per cycle, starting the first cycle after reset deasserts.
  - lu_ready = up_ready = 0 throughout INIT.
- **Lookup FSM (L_IDLE → L_CALC → L_IDLE):**
  - lu_ready = 1 only in L_IDLE while in RUN. At most one lookup is outstanding.
  - L_CALC uses the table data and the current GHR. It registers pred_* and shifts the GHR as {GHR[GHR_LEN-2:0], pred_taken}.
- **Update FSM (U_IDLE → U_READ → U_WRITE → U_IDLE):** up_ready = 1 only in U_IDLE while in RUN.
- **Training rule:** train when up_mispred or |up_sum| ≤ THETA.
  - w0 += up_taken ? +1 : −1.
  - w(i+1) += (up_taken == up_ghr[i]) ? +1 : −1.
  - Each result saturates at ±(2^(W_BITS-1)-1).
  - When training is not required, no write occurs (U_WRITE has write-enable low).
- **Repair:** when an update is accepted with up_mispred = 1, the GHR loads {up_ghr[GHR_LEN-2:0], up_taken} at that edge.
  - Repair beats the speculative shift in the same cycle.
  - A lookup in L_CALC during a repair is squashed: pred_valid stays 0 and the FSM returns to L_IDLE.

## Timing
- Reset values: lu_ready=0, up_ready=0, pred_valid=0, pred_taken=0, pred_sum=0, pred_ghr=0, GHR=0.
- Init lasts 2^IDX_BITS cycles; lu_ready/up_ready rise on the following cycle.
- Lookup accepted in cycle N:
  - cycle N+1 is L_CALC with lu_ready=0;
  - pred_valid=1 in N+2 only;
  - lu_ready=1 again in N+2.
  - The shifted GHR is visible in N+2, so a lookup accepted in N+2 sees it.
- Update accepted in cycle M:
  - weights read at edge M;
  - new weights registered at end of M+1;
  - write at end of M+2;
  - up_ready=1 again in M+3.
  - A lookup of the same index reading before end of M+2 gets the old weights.
- Reset asserted mid-lookup or mid-update aborts immediately with no partial write. INIT restarts from entry 0.
- Inputs are ignored while the corresponding ready is low.

## Test plan
- **Init:** Reset, then count cycles until lu_ready=1. Required: exactly 64 after reset deassert. Then lookup lu_pc=0x40 gives pred_valid 2 cycles later with pred_sum=0, pred_taken=1, pred_ghr=0.
- **Training:** Update up_pc=0x40, up_taken=0, up_mispred=1, up_ghr=0, up_sum=0. Then lookup 0x40 with GHR=0. Required: pred_sum=−13, pred_taken=0; pred_ghr is the repaired value 0.
- **Saturation:** 200 updates at pc 0x80 with up_taken=1, up_ghr=0xFFF, up_sum=0, mispred=0. Force GHR=0xFFF via repair. Required: lookup 0x80 gives pred_sum=1651; a further update leaves it at 1651.
- **Threshold:** Update with up_mispred=0, up_sum=38. Required: no table write (entry unchanged). With up_sum=−37, the entry is trained.
- **Repair and squash:** Lookup accepted in cycle N; mispredict update accepted in N+1 with up_ghr=0x0A5, up_taken=1. Required: no pred_valid in N+2; GHR=0x14B; the next lookup's pred_ghr=0x14B.
- **Reset mid-operation:** Assert reset in cycle M+1 of an update and during an outstanding lookup. Required: all outputs 0 immediately, no pred_valid. After 64 init cycles the target entry reads all zero.

Source files
------------

// File: rtl/perceptron_predictor.sv
// perceptron_predictor: perceptron branch-direction predictor with speculative GHR, checkpoint repair and table init
module perceptron_predictor #(
  parameter int GHR_LEN = 12,
  parameter int W_BITS = 8,
  parameter int IDX_BITS = 6,
  parameter int THETA = 37,
  localparam int SUM_BITS = W_BITS + $clog2(GHR_LEN + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_lu_valid,
  input  logic [31:0]                i_lu_pc,
  output logic                       o_lu_ready,
  output logic                       o_pred_valid,
  output logic                       o_pred_taken,
  output logic signed [SUM_BITS-1:0] o_pred_sum,
  output logic [GHR_LEN-1:0]         o_pred_ghr,
  input  logic                       i_up_valid,
  output logic                       o_up_ready,
  input  logic [31:0]                i_up_pc,
  input  logic                       i_up_taken,
  input  logic                       i_up_mispred,
  input  logic [GHR_LEN-1:0]         i_up_ghr,
  input  logic signed [SUM_BITS-1:0] i_up_sum
);
  localparam int NW = GHR_LEN + 1;
  localparam int EW = NW * W_BITS;
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [W_BITS-1:0] WMAX = {1'b0, {(W_BITS-1){1'b1}}};
  localparam logic [W_BITS-1:0] WMIN = {1'b1, {(W_BITS-2){1'b0}}, 1'b1};
  localparam logic signed [SUM_BITS-1:0] THETA_S = SUM_BITS'(THETA);

  typedef enum logic {M_INIT, M_RUN} mode_t;
  typedef enum logic {L_IDLE, L_CALC} lu_t;
  typedef enum logic [1:0] {U_IDLE, U_READ, U_WRITE} up_t;

  mode_t r_mode, w_mode_nxt;
  lu_t r_lu_st, w_lu_nxt;
  up_t r_up_st, w_up_nxt;

  logic [EW-1:0] r_mem [ENTRIES];
  logic [EW-1:0] r_lu_data, r_up_data, r_new, w_new, w_wdata;
  logic [IDX_BITS-1:0] r_init_cnt, r_up_idx, w_waddr;
  logic [GHR_LEN-1:0] r_ghr, r_up_ghr, r_pred_ghr;
  logic [NW-1:0] w_dir;
  logic r_up_taken, r_train, r_pred_valid, r_pred_taken;
  logic signed [SUM_BITS-1:0] r_pred_sum, w_sum;
  logic w_lu_acc, w_up_acc, w_repair, w_emit, w_train, w_we, w_unused;

  function automatic logic signed [SUM_BITS-1:0] f_ext(input logic [W_BITS-1:0] w);
    return SUM_BITS'($signed(w));
  endfunction

  function automatic logic [W_BITS-1:0] f_sat(input logic [W_BITS-1:0] w, input logic inc);
    return inc ? (w == WMAX ? w : w + W_BITS'(1)) : (w == WMIN ? w : w - W_BITS'(1));
  endfunction

  assign o_lu_ready = r_mode == M_RUN && r_lu_st == L_IDLE;
  assign o_up_ready = r_mode == M_RUN && r_up_st == U_IDLE;
  assign o_pred_valid = r_pred_valid;
  assign o_pred_taken = r_pred_taken;
  assign o_pred_sum = r_pred_sum;
  assign o_pred_ghr = r_pred_ghr;
  assign w_lu_acc = i_lu_valid & o_lu_ready;
  assign w_up_acc = i_up_valid & o_up_ready;
  assign w_repair = w_up_acc & i_up_mispred;
  assign w_emit = r_lu_st == L_CALC && !w_repair;
  assign w_train = i_up_mispred | (i_up_sum <= THETA_S && i_up_sum >= -THETA_S);
  assign w_dir = {~(r_up_ghr ^ {GHR_LEN{r_up_taken}}), r_up_taken};
  assign w_we = !i_reset && (r_mode == M_INIT || (r_up_st == U_WRITE && r_train));
  assign w_waddr = r_mode == M_INIT ? r_init_cnt : r_up_idx;
  assign w_wdata = r_mode == M_INIT ? '0 : r_new;
  assign w_unused = ^{i_lu_pc[31:IDX_BITS+2], i_lu_pc[1:0], i_up_pc[31:IDX_BITS+2], i_up_pc[1:0]};

  // dot product of the looked-up weights against the current speculative history
  always_comb begin
    w_sum = f_ext(r_lu_data[W_BITS-1:0]);
    for (int k = 0; k < GHR_LEN; k++)
      w_sum = r_ghr[k] ? w_sum + f_ext(r_lu_data[(k+1)*W_BITS +: W_BITS]) : w_sum - f_ext(r_lu_data[(k+1)*W_BITS +: W_BITS]);
  end

  // saturating perceptron step: bias follows the outcome, others follow agreement with history
  always_comb begin
    w_new = '0;
    for (int k = 0; k < NW; k++)
      w_new[k*W_BITS +: W_BITS] = f_sat(r_up_data[k*W_BITS +: W_BITS], w_dir[k]);
  end

  // next-state logic for init, lookup and update sequencers
  always_comb begin
    w_mode_nxt = (r_mode == M_INIT && r_init_cnt == '1) ? M_RUN : r_mode;
    w_lu_nxt = (r_lu_st == L_IDLE && w_lu_acc) ? L_CALC : L_IDLE;
    w_up_nxt = r_up_st == U_IDLE ? (w_up_acc ? U_READ : U_IDLE) : r_up_st == U_READ ? U_WRITE : U_IDLE;
  end

  // weight table: one write port shared by init and training, two synchronous read ports
  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    if (w_lu_acc) r_lu_data <= r_mem[i_lu_pc[IDX_BITS+1:2]];
    if (w_up_acc) r_up_data <= r_mem[i_up_pc[IDX_BITS+1:2]];
  end

  // state, GHR (repair beats speculative shift), prediction outputs and update context
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mode <= M_INIT;
      r_lu_st <= L_IDLE;
      r_up_st <= U_IDLE;
      r_init_cnt <= '0;
      r_ghr <= '0;
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_sum <= '0;
      r_pred_ghr <= '0;
      r_up_idx <= '0;
      r_up_taken <= 1'b0;
      r_up_ghr <= '0;
      r_train <= 1'b0;
      r_new <= '0;
    end else begin
      r_mode <= w_mode_nxt;
      r_lu_st <= w_lu_nxt;
      r_up_st <= w_up_nxt;
      r_init_cnt <= r_mode == M_INIT ? r_init_cnt + IDX_BITS'(1) : r_init_cnt;
      r_pred_valid <= w_emit;
      if (w_emit) begin
        r_pred_sum <= w_sum;
        r_pred_taken <= !w_sum[SUM_BITS-1];
        r_pred_ghr <= r_ghr;
      end
      r_ghr <= w_repair ? {i_up_ghr[GHR_LEN-2:0], i_up_taken} : w_emit ? {r_ghr[GHR_LEN-2:0], !w_sum[SUM_BITS-1]} : r_ghr;
      if (w_up_acc) begin
        r_up_idx <= i_up_pc[IDX_BITS+1:2];
        r_up_taken <= i_up_taken;
        r_up_ghr <= i_up_ghr;
        r_train <= w_train;
      end
      if (r_up_st == U_READ) r_new <= w_new;
    end
  end
endmodule
